// File: rtl/addr_burst_seq.sv
// Registered address burst sequencer: issues len addresses from start_addr over valid/ready,
// stepping +1/-1 per accepted beat. Define ADDR_BURST_WRAP_EN to let addresses wrap modulo 2^AW.
module addr_burst_seq #(
  parameter int AW = 16,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [LW-1:0] len,
  input  logic          dir,
  output logic [AW-1:0] addr,
  output logic          addr_valid,
  input  logic          addr_ready,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          dir_q, dir_d;
  logic          err_q, err_d;

  logic          beat_acc;
  logic          last_beat;
  logic [AW-1:0] addr_step;

  assign beat_acc  = (state_q == S_RUN) && addr_ready;
  assign last_beat = (rem_q == LW'(1));
  assign addr_step = dir_q ? (addr_q - AW'(1)) : (addr_q + AW'(1));

`ifndef ADDR_BURST_WRAP_EN
  // Next step would leave the address space: ascending from all-ones or descending from zero.
  logic at_edge;
  assign at_edge = dir_q ? (addr_q == '0) : (addr_q == '1);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (len != '0) begin
            addr_d  = start_addr;
            rem_d   = len;
            dir_d   = dir;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (beat_acc) begin
          if (last_beat) begin
            rem_d   = '0;
            state_d = S_DONE;
          end else begin
`ifdef ADDR_BURST_WRAP_EN
            addr_d = addr_step;
            rem_d  = rem_q - LW'(1);
`else
            if (at_edge) begin
              rem_d   = '0;
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              addr_d = addr_step;
              rem_d  = rem_q - LW'(1);
            end
`endif
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from registered state, so they clear the instant reset asserts.
  assign addr       = addr_q;
  assign addr_valid = (state_q == S_RUN);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_addr_burst_seq.sv
// Self-checking bench for addr_burst_seq: directed bursts plus randomized bursts and
// backpressure, checked against a closed-form model of the expected address sequence.
module tb_addr_burst_seq;
  localparam int AW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] len;
  logic          dir;
  logic [AW-1:0] addr;
  logic          addr_valid;
  logic          addr_ready;
  logic          busy;
  logic          done;
  logic          err;

  int n_chk = 0;
  int n_err = 0;

  addr_burst_seq #(.AW(AW), .LW(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .len       (len),
    .dir       (dir),
    .addr      (addr),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Number of beats the burst issues: len, unless truncated at the address-space edge.
  function automatic int exp_beats(input int sa, input int ln, input bit dr);
    int room;
    room = dr ? (sa + 1) : ((1 << AW) - sa);
`ifdef ADDR_BURST_WRAP_EN
    room = 1 << LW;
`endif
    return (ln < room) ? ln : room;
  endfunction

  task automatic run_burst(input string tag, input int sa, input int ln, input bit dr,
                           input int pct, input int stall_beat, input int stall_len,
                           input bit junk_start);
    int            n_exp;
    bit            e_err;
    int            idx;
    int            stall_cnt;
    int            bound;
    bit            finished;
    bit            exp_done;
    logic [AW-1:0] exp_addr;
    n_exp     = exp_beats(sa, ln, dr);
    e_err     = (n_exp < ln);
    idx       = 0;
    stall_cnt = 0;
    bound     = 8 * ln + 20;
    finished  = 1'b0;
    start      = 1'b1;
    start_addr = AW'(sa);
    len        = LW'(ln);
    dir        = dr;
    addr_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < bound; cyc++) begin
      if (idx == stall_beat && stall_cnt < stall_len) begin
        addr_ready = 1'b0;
        stall_cnt++;
      end else begin
        addr_ready = ($urandom_range(0, 99) < pct);
      end
      // Fresh launch attempts with unrelated values must be ignored mid-burst.
      if (junk_start) begin
        start      = ($urandom_range(0, 3) == 0);
        start_addr = AW'($urandom);
        len        = LW'($urandom);
        dir        = 1'($urandom);
      end
      @(negedge clk);
      exp_done = (idx == n_exp);
      chk({tag, " done"}, done, exp_done);
      chk({tag, " valid"}, addr_valid, !exp_done);
      chk({tag, " busy"}, busy, 1);
      chk({tag, " err"}, err, exp_done ? e_err : 1'b0);
      if (!exp_done && addr_valid) begin
        exp_addr = dr ? AW'(sa - idx) : AW'(sa + idx);
        chk({tag, " addr"}, addr, exp_addr);
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
      if (addr_valid && addr_ready) idx++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    addr_ready = 1'b0;
    chk({tag, " finished in budget"}, finished, 1);
    chk({tag, " beats"}, idx, n_exp);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle done"}, done, 0);
    chk({tag, " idle valid"}, addr_valid, 0);
    chk({tag, " err sticky"}, err, e_err);
  endtask

  initial begin
    int sa;
    int ln;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    len        = '0;
    dir        = 1'b0;
    addr_ready = 1'b0;
    #12;
    chk("reset addr", addr, 0);
    chk("reset valid", addr_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_burst("asc", 16'h1000, 4, 1'b0, 100, -1, 0, 1'b0);
    run_burst("desc_bp", 16'h0010, 3, 1'b1, 100, 1, 2, 1'b0);
    run_burst("zero_len", 16'h1234, 0, 1'b0, 100, -1, 0, 1'b0);
    run_burst("boundary", 16'hFFFE, 4, 1'b0, 100, -1, 0, 1'b0);
    run_burst("boundary_dn", 16'h0001, 4, 1'b1, 100, -1, 0, 1'b0);
    run_burst("ignored_start", 16'h4000, 6, 1'b0, 70, -1, 0, 1'b1);

    // Reset during beat 2 of a 5-beat burst.
    start      = 1'b1;
    start_addr = 16'h2000;
    len        = 8'd5;
    dir        = 1'b0;
    addr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid rst beat2 addr", addr, 16'h2001);
    chk("mid rst beat2 valid", addr_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst addr", addr, 0);
    chk("mid rst valid", addr_valid, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst done", done, 0);
    chk("mid rst err", err, 0);
    addr_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in rst done", done, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post rst busy", busy, 0);
    chk("post rst valid", addr_valid, 0);
    run_burst("post_rst", 16'h2000, 5, 1'b0, 100, -1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       sa = int'($urandom_range(0, 65535));
        1:       sa = 65535 - int'($urandom_range(0, 10));
        default: sa = int'($urandom_range(0, 10));
      endcase
      ln = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 12));
      run_burst("rand", sa, ln, 1'($urandom), int'($urandom_range(40, 100)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
